piso_serializer: RTL

PISO_SERIALIZER -- requirements
Module: piso_serializer

---
 rtl/piso_serializer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out shifter (MSB first) with a ready/valid load port.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits of every word.
module piso_serializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] Din,
    input  logic             Load_valid,
    output logic             Load_ready,
    output logic             Sout,
    output logic             Sout_valid,
    output logic             Busy,
    output logic [1:0]       CS
);

    localparam int unsigned      CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0]  CntLast = CntW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
        StParity = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1
    } state_e;
`endif

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             last_data;
    logic             accept;
`ifdef PISO_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign last_data = (state_q == StShift) && (cnt_q == CntLast);

    // The word's final cycle is the parity cycle when parity is on, else the last data bit.
`ifdef PISO_PARITY_EN
    assign Load_ready = (state_q == StIdle) || (state_q == StParity);
`else
    assign Load_ready = (state_q == StIdle) || last_data;
`endif

    assign accept = Load_valid && Load_ready;
    assign Busy   = (state_q != StIdle);
    assign CS     = state_q;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            StIdle: ;
            StShift: begin
                shift_d = shift_q << 1;
                if (last_data) begin
                    cnt_d = '0;
`ifdef PISO_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StIdle;
`endif
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
`ifdef PISO_PARITY_EN
            StParity: begin
                state_d  = StIdle;
                parity_d = 1'b0;
            end
`endif
            default: begin
                // Unused encoding recovers to idle with clean datapath state.
                state_d = StIdle;
                shift_d = '0;
                cnt_d   = '0;
            end
        endcase

        // An accepted load overrides the end-of-word transition, giving gap-free streaming.
        if (accept) begin
            state_d = StShift;
            shift_d = Din;
            cnt_d   = '0;
`ifdef PISO_PARITY_EN
            parity_d = ^Din;
`endif
        end
    end

    always_comb begin
        Sout       = 1'b0;
        Sout_valid = 1'b0;
        case (state_q)
            StShift: begin
                Sout       = shift_q[WIDTH-1];
                Sout_valid = 1'b1;
            end
`ifdef PISO_PARITY_EN
            StParity: begin
                Sout       = parity_q;
                Sout_valid = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
`ifdef PISO_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule
